// File: rtl/stack_host.sv
// Command initiator for the pin-level LIFO stack: sequences push/pop strobes,
// mirrors occupancy and returns one response per command. Optional: STACK_HOST_TIMEOUT_EN.
module stack_host #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_pop,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [DATA_W-1:0]          stk_wdata,
    output logic                       stk_oe,
    input  logic [DATA_W-1:0]          stk_rdata,
    input  logic                       stk_done,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    localparam int DW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    state_t            state, state_nx;
    logic              op_pop;
    logic [DATA_W-1:0] op_data;
    logic              reject;
    logic              tmo_hit;

    assign full   = (depth == DW'(DEPTH));
    assign empty  = (depth == '0);
    assign reject = cmd_pop ? empty : full;

`ifdef STACK_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] tmo_cnt;

    // Counts completed wait cycles; the wait cycle that sees TIMEOUT-1 is the last one.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    // Timeout disabled: never fires, waits are unbounded.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cmd_valid) state_nx = reject ? RESP : ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!stk_done) state_nx = WAIT_DONE;
                       else if (tmo_hit) state_nx = RESP;
            WAIT_DONE: if (stk_done || tmo_hit) state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_pop   <= 1'b0;
            op_data  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            depth    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (cmd_valid) begin
                    op_pop  <= cmd_pop;
                    op_data <= cmd_data;
                    if (reject) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                WAIT_BUSY: if (stk_done && tmo_hit) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
                WAIT_DONE: if (stk_done) begin
                    rsp_err  <= 1'b0;
                    rsp_data <= op_pop ? stk_rdata : '0;
                end else if (tmo_hit) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
                RESP: if (!rsp_err) begin
                    depth <= op_pop ? depth - DW'(1) : depth + DW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: strobes and bus controls decode from the registered state, so the
    // asynchronous reset releases them immediately.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign stk_push  = (state == ISSUE) && !op_pop;
    assign stk_pop   = (state == ISSUE) && op_pop;
    assign stk_oe    = !op_pop && (state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE);
    assign stk_wdata = stk_oe ? op_data : '0;

endmodule

// File: tb/tb_stack_host.sv
// Self-checking bench for stack_host: behavioural stack device plus a queue-based
// reference of the expected stack contents; directed and random push/pop traffic.
module tb_stack_host;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 63;
    localparam int DW      = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_pop;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_wdata;
    logic              stk_oe;
    logic [DATA_W-1:0] stk_rdata;
    logic              stk_done;
    logic [DW-1:0]     depth;
    logic              full;
    logic              empty;

    stack_host #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pop(cmd_pop), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_oe(stk_oe),
        .stk_rdata(stk_rdata), .stk_done(stk_done),
        .depth(depth), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stack device model: drops done for `hold` cycles after a strobe, then commits.
    logic [DATA_W-1:0] dev_q[$];
    int                busy    = 0;
    int                hold    = 2;
    int                strobes = 0;
    bit                hang    = 0;
    bit                pend_pop;
    logic [DATA_W-1:0] pend_data;

    initial begin
        stk_done  = 1'b1;
        stk_rdata = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                dev_q.delete();
                busy      = 0;
                stk_done  = 1'b1;
                stk_rdata = '0;
                continue;
            end
            #1;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    if (pend_pop) stk_rdata = (dev_q.size() > 0) ? dev_q.pop_back() : '0;
                    else          dev_q.push_back(pend_data);
                    stk_done = 1'b1;
                end
            end else if (stk_push || stk_pop) begin
                strobes++;
                if (!hang) begin
                    pend_pop  = stk_pop;
                    pend_data = stk_wdata;
                    busy      = hold;
                    stk_done  = 1'b0;
                end
            end
        end
    end

    // Reference: contents the host should believe the stack holds.
    logic [DATA_W-1:0] ref_q[$];

    task automatic reset_values(input string pfx);
        check({pfx, "_ready"}, cmd_ready, 1);
        check({pfx, "_rvalid"}, rsp_valid, 0);
        check({pfx, "_rdata"}, rsp_data, 0);
        check({pfx, "_rerr"}, rsp_err, 0);
        check({pfx, "_strobes"}, {stk_push, stk_pop}, 0);
        check({pfx, "_bus"}, {stk_oe, stk_wdata}, 0);
        check({pfx, "_depth"}, depth, 0);
        check({pfx, "_flags"}, {full, empty}, 2'b01);
    endtask

    task automatic do_cmd(input bit pop, input logic [DATA_W-1:0] data);
        bit                rej;
        int                n;
        int                s0;
        int                bus_bad;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W:0]   exp_bus;
        bit                exp_err;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready", cmd_ready, 1);
        rej = pop ? (ref_q.size() == 0) : (ref_q.size() == DEPTH);
        s0  = strobes;
        cmd_valid = 1'b1; cmd_pop = pop; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_pop = 1'b0; cmd_data = DATA_W'($urandom);
        if (rej) begin
            check("rej_valid", rsp_valid, 1);
            check("rej_err", rsp_err, 1);
            check("rej_data", rsp_data, 0);
            check("rej_strobe", {stk_push, stk_pop}, 0);
            @(posedge clk); #1;
            check("rej_pulse", rsp_valid, 0);
            check("rej_depth", depth, ref_q.size());
            check("rej_nostrobe", strobes - s0, 0);
            return;
        end
        exp_bus = pop ? '0 : {1'b1, data};
        check("strobe", {stk_push, stk_pop}, pop ? 2'b01 : 2'b10);
        check("issue_bus", {stk_oe, stk_wdata}, exp_bus);
        @(posedge clk); #1;
        check("strobe_width", {stk_push, stk_pop}, 0);
        n = 1; bus_bad = 0;
        while (!rsp_valid && n < 200) begin
            if ({stk_oe, stk_wdata} !== exp_bus) bus_bad++;
            @(posedge clk); #1; n++;
        end
        check("rsp_seen", rsp_valid, 1);
        check("bus_hold", bus_bad, 0);
        check("resp_bus", {stk_oe, stk_wdata}, 0);
        check("one_strobe", strobes - s0, 1);
        if (hang) begin
            check("tmo_wait", n - 1, TIMEOUT);
            exp_err  = 1'b1;
            exp_data = '0;
        end else begin
            check("min_lat", (n >= 3), 1);
            exp_err  = 1'b0;
            exp_data = pop ? ref_q.pop_back() : '0;
            if (!pop) ref_q.push_back(data);
        end
        check("rsp_err", rsp_err, exp_err);
        check("rsp_data", rsp_data, exp_data);
        @(posedge clk); #1;
        check("rsp_pulse", rsp_valid, 0);
        check("rsp_hold", {rsp_err, rsp_data}, {exp_err, exp_data});
        check("depth", depth, ref_q.size());
        check("flags", {full, empty}, {ref_q.size() == DEPTH, ref_q.size() == 0});
    endtask

    initial begin
        int bad;
        bit pop;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_pop = 1'b0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_values("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        reset_values("post_rst");

        // Single push with done dropped for two cycles.
        hold = 2;
        do_cmd(1'b0, 8'hA5);

        // LIFO ordering, then drain to empty and underflow.
        do_cmd(1'b0, 8'h11);
        do_cmd(1'b0, 8'h22);
        do_cmd(1'b0, 8'h33);
        for (int i = 0; i < 4; i++) do_cmd(1'b1, 8'h00);
        do_cmd(1'b1, 8'h00);

        // Fill to capacity, overflow, drain.
        for (int i = 0; i < DEPTH; i++) begin
            hold = $urandom_range(2, 4);
            do_cmd(1'b0, DATA_W'($urandom));
        end
        do_cmd(1'b0, 8'hEE);
        for (int i = 0; i < DEPTH; i++) do_cmd(1'b1, 8'h00);

        // Random traffic biased to visit both boundaries.
        for (int i = 0; i < 120; i++) begin
            hold = $urandom_range(2, 5);
            if (ref_q.size() == 0)          pop = ($urandom_range(0, 3) == 0);
            else if (ref_q.size() == DEPTH) pop = ($urandom_range(0, 3) != 0);
            else                            pop = ($urandom_range(0, 1) == 1);
            do_cmd(pop, DATA_W'($urandom));
        end

`ifdef STACK_HOST_TIMEOUT_EN
        // Stack never acknowledges: the host must give up and leave depth alone.
        hang = 1'b1;
        do_cmd(1'b0, 8'h5C);
        hang = 1'b0;
`endif

        // Reset while a pop sits in WAIT_DONE.
        hold = 2;
        do_cmd(1'b0, 8'h5A);
        do_cmd(1'b0, 8'h6B);
        hold = 12;
        cmd_valid = 1'b1; cmd_pop = 1'b1; cmd_data = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_pop = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        reset_values("mid_rst");
        ref_q.delete();
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) bad++;
        end
        check("mid_rst_norsp", bad, 0);
        rst_n = 1'b1;
        hold = 2;
        do_cmd(1'b0, 8'hC3);
        do_cmd(1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
